// File: rtl/regfile_param_bypass.sv
// Parametrised integer register file: two combinational read ports, one write port,
// hard-wired zero entry, optional write-to-read bypass and a post-reset clearing sweep.
module regfile_param_bypass #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_rd_we,
    input  logic [XLEN-1:0]   i_rd_data,
    output logic [XLEN-1:0]   o_rs1_data,
    output logic [XLEN-1:0]   o_rs2_data,
    output logic              o_ready,
    output logic              o_write_dropped
);

    localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_init_idx;
    logic [ADDR_W-1:0] w_init_idx_next;
    logic              r_write_dropped;
    logic              w_ready;
    logic              w_wr_en;
    logic              w_drop;
    logic              w_rd_valid;
    logic              w_rs1_valid;
    logic              w_rs2_valid;
    logic [XLEN-1:0]   w_rs1_data;
    logic [XLEN-1:0]   w_rs2_data;

    // Storage has no reset so it can map onto RAM; the sweep clears it instead.
    logic [XLEN-1:0]   r_mem [NUM_REGS];

    assign w_rd_valid  = (i_rd_addr  != '0) && ({1'b0, i_rd_addr}  < NUM_REGS_W);
    assign w_rs1_valid = (i_rs1_addr != '0) && ({1'b0, i_rs1_addr} < NUM_REGS_W);
    assign w_rs2_valid = (i_rs2_addr != '0) && ({1'b0, i_rs2_addr} < NUM_REGS_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_INIT;
            r_init_idx      <= ADDR_W'(1);
            r_write_dropped <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_init_idx      <= w_init_idx_next;
            r_write_dropped <= w_drop;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_init_idx_next = r_init_idx;
        w_ready         = 1'b0;
        w_wr_en         = 1'b0;
        w_drop          = 1'b0;
        case (r_state)
            S_INIT: begin
                w_init_idx_next = r_init_idx + ADDR_W'(1);
                w_drop          = i_rd_we && (i_rd_addr != '0);
                if (r_init_idx == LAST_IDX) begin
                    w_state_next = S_READY;
                end
            end
            S_READY: begin
                w_ready = 1'b1;
                w_wr_en = i_rd_we && w_rd_valid;
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_init_idx[IDX_W-1:0]] <= '0;
        end else if (w_wr_en) begin
            r_mem[i_rd_addr[IDX_W-1:0]] <= i_rd_data;
        end
    end

    // Entry 0, out-of-range addresses and the INIT state all read as zero.
    always_comb begin
        w_rs1_data = '0;
        if (w_ready && w_rs1_valid) begin
            if ((BYPASS != 0) && w_wr_en && (i_rd_addr == i_rs1_addr)) begin
                w_rs1_data = i_rd_data;
            end else begin
                w_rs1_data = r_mem[i_rs1_addr[IDX_W-1:0]];
            end
        end
    end

    always_comb begin
        w_rs2_data = '0;
        if (w_ready && w_rs2_valid) begin
            if ((BYPASS != 0) && w_wr_en && (i_rd_addr == i_rs2_addr)) begin
                w_rs2_data = i_rd_data;
            end else begin
                w_rs2_data = r_mem[i_rs2_addr[IDX_W-1:0]];
            end
        end
    end

    assign o_rs1_data      = w_rs1_data;
    assign o_rs2_data      = w_rs2_data;
    assign o_ready         = w_ready;
    assign o_write_dropped = r_write_dropped;

endmodule

// File: tb/tb_regfile_param_bypass.sv
// Bench for regfile_param_bypass: three instances (default, no bypass, 16 entries)
// share stimulus and are checked against an array-based reference model.
module tb_regfile_param_bypass;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [4:0]  rd = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;

    logic [31:0] r1 [3];
    logic [31:0] r2 [3];
    logic        rdy [3];
    logic        drp [3];

    int tests = 0;
    int fails = 0;

    // Model: index 0 serves the 32-entry instances, index 1 the 16-entry one.
    logic [31:0] mem [2][32];
    int          cnt [2];
    bit          drop [2];
    int          nreg [2] = '{32, 16};

    always #5 clk = ~clk;

    regfile_param_bypass uA (
        .clk(clk), .rst_n(rst_n), .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rd_addr(rd),
        .i_rd_we(we), .i_rd_data(wdata), .o_rs1_data(r1[0]), .o_rs2_data(r2[0]),
        .o_ready(rdy[0]), .o_write_dropped(drp[0])
    );

    regfile_param_bypass #(.BYPASS(0)) uB (
        .clk(clk), .rst_n(rst_n), .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rd_addr(rd),
        .i_rd_we(we), .i_rd_data(wdata), .o_rs1_data(r1[1]), .o_rs2_data(r2[1]),
        .o_ready(rdy[1]), .o_write_dropped(drp[1])
    );

    regfile_param_bypass #(.NUM_REGS(16)) uC (
        .clk(clk), .rst_n(rst_n), .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rd_addr(rd),
        .i_rd_we(we), .i_rd_data(wdata), .o_rs1_data(r1[2]), .o_rs2_data(r2[2]),
        .o_ready(rdy[2]), .o_write_dropped(drp[2])
    );

    function automatic int modelOf(int k);
        return (k == 2) ? 1 : 0;
    endfunction

    function automatic bit expReady(int k);
        int m = modelOf(k);
        return cnt[m] >= nreg[m] - 1;
    endfunction

    function automatic logic [31:0] expRead(int k, logic [4:0] a);
        int m = modelOf(k);
        bit byp = (k != 1);
        if (!expReady(k) || a == 0 || int'(a) >= nreg[m]) return 32'h0;
        if (byp && we && rd != 0 && int'(rd) < nreg[m] && rd == a) return wdata;
        return mem[m][a];
    endfunction

    task automatic modelEdge();
        for (int m = 0; m < 2; m++) begin
            drop[m] = (cnt[m] < nreg[m] - 1) && we && (rd != 0);
            if (cnt[m] < nreg[m] - 1) begin
                mem[m][cnt[m] + 1] = 32'h0;
                cnt[m]++;
            end else if (we && rd != 0 && int'(rd) < nreg[m]) begin
                mem[m][rd] = wdata;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) modelEdge();
        @(negedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            cnt[m]  = 0;
            drop[m] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (rdy[k] !== 1'b0 || drp[k] !== 1'b0 || r1[k] !== 32'h0) begin
                fails++;
                $display("[TB] FAIL reset_state inst%0d: ready=%b dropped=%b rs1=%h, required 0 0 0", k, rdy[k], drp[k], r1[k]);
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            tick();
            rs1 = 5'($urandom_range(31, 0));
            rs2 = 5'($urandom_range(31, 0));
            #1;
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (rdy[k] !== expReady(k) || r1[k] !== expRead(k, rs1) || r2[k] !== expRead(k, rs2)) begin
                    fails++;
                    $display("[TB] FAIL init_sweep edge%0d inst%0d: ready=%b rs1=%h rs2=%h, required %b %h %h", e, k, rdy[k], r1[k], r2[k], expReady(k), expRead(k, rs1), expRead(k, rs2));
                end
            end
        end
        tests++;
        if (rdy[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ready_after_31: ready=%b, required 1", rdy[0]);
        end
    endtask

    task automatic test_write();
        we = 1'b1; rd = 5'd5; wdata = 32'hDEADBEEF; rs1 = 5'd0; rs2 = 5'd0;
        tick();
        we = 1'b0; rs1 = 5'd5; rs2 = 5'd5;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (r1[k] !== 32'hDEADBEEF || r2[k] !== 32'hDEADBEEF) begin
                fails++;
                $display("[TB] FAIL write_x5 inst%0d: rs1=%h rs2=%h, required deadbeef", k, r1[k], r2[k]);
            end
        end
        we = 1'b1; rd = 5'd0; wdata = 32'h1234; rs1 = 5'd0;
        tick();
        we = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (r1[k] !== 32'h0) begin
                fails++;
                $display("[TB] FAIL write_x0 inst%0d: rs1=%h, required 0", k, r1[k]);
            end
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; rd = 5'd7; wdata = 32'h11;
        tick();
        wdata = 32'h22; rs1 = 5'd7; rs2 = 5'd7;
        #1;
        tests++;
        if (r1[0] !== 32'h22 || r2[2] !== 32'h22) begin
            fails++;
            $display("[TB] FAIL bypass_on: rs1=%h rs2=%h, required 22 22", r1[0], r2[2]);
        end
        tests++;
        if (r1[1] !== 32'h11 || r2[1] !== 32'h11) begin
            fails++;
            $display("[TB] FAIL bypass_off_before: rs1=%h rs2=%h, required 11 11", r1[1], r2[1]);
        end
        tick();
        we = 1'b0;
        #1;
        tests++;
        if (r1[1] !== 32'h22) begin
            fails++;
            $display("[TB] FAIL bypass_off_after: rs1=%h, required 22", r1[1]);
        end
    endtask

    task automatic test_out_of_range();
        we = 1'b1; rd = 5'd20; wdata = 32'h55;
        tick();
        rd = 5'd15; wdata = 32'h66;
        tick();
        we = 1'b0; rs1 = 5'd20; rs2 = 5'd4;
        #1;
        tests++;
        if (r1[2] !== 32'h0 || r2[2] !== 32'h0) begin
            fails++;
            $display("[TB] FAIL oor_16 x20/x4: rs1=%h rs2=%h, required 0 0", r1[2], r2[2]);
        end
        tests++;
        if (r1[0] !== 32'h55) begin
            fails++;
            $display("[TB] FAIL inrange_32 x20: rs1=%h, required 55", r1[0]);
        end
        rs1 = 5'd15; rs2 = 5'd16;
        #1;
        tests++;
        if (r1[2] !== 32'h66 || r2[2] !== 32'h0) begin
            fails++;
            $display("[TB] FAIL edge_16 x15/x16: rs1=%h rs2=%h, required 66 0", r1[2], r2[2]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            we    = 1'($urandom_range(1, 0));
            rd    = 5'($urandom_range(31, 0));
            wdata = $urandom;
            rs1   = ($urandom_range(3, 0) == 0) ? rd : 5'($urandom_range(31, 0));
            rs2   = ($urandom_range(3, 0) == 0) ? rs1 : 5'($urandom_range(31, 0));
            #1;
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (r1[k] !== expRead(k, rs1) || r2[k] !== expRead(k, rs2)) begin
                    fails++;
                    $display("[TB] FAIL random%0d inst%0d: rs1=%h rs2=%h, required %h %h", i, k, r1[k], r2[k], expRead(k, rs1), expRead(k, rs2));
                end
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (drp[k] !== drop[modelOf(k)] || rdy[k] !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL random_status%0d inst%0d: dropped=%b ready=%b, required %b 1", i, k, drp[k], rdy[k], drop[modelOf(k)]);
                end
            end
        end
        we = 1'b0;
    endtask

    task automatic test_drop();
        rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        we = 1'b1; rd = 5'd4; wdata = 32'hAA;
        tick();
        we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (drp[k] !== 1'b1 || drp[k] !== drop[modelOf(k)]) begin
                fails++;
                $display("[TB] FAIL drop_pulse inst%0d: dropped=%b, required 1", k, drp[k]);
            end
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (drp[k] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL drop_clear inst%0d: dropped=%b, required 0", k, drp[k]);
            end
        end
        for (int i = 0; i < 40 && !expReady(0); i++) tick();
        rs1 = 5'd4; rs2 = 5'd4;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (rdy[k] !== 1'b1 || r1[k] !== 32'h0 || r2[k] !== 32'h0) begin
                fails++;
                $display("[TB] FAIL drop_x4 inst%0d: ready=%b rs1=%h rs2=%h, required 1 0 0", k, rdy[k], r1[k], r2[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        we = 1'b1; rd = 5'd3; wdata = 32'h77;
        tick();
        we = 1'b0; rs1 = 5'd3; rs2 = 5'd3;
        #1;
        tests++;
        if (r1[0] !== 32'h77 || r2[2] !== 32'h77) begin
            fails++;
            $display("[TB] FAIL pre_reset_x3: rs1=%h rs2=%h, required 77 77", r1[0], r2[2]);
        end
        tick();
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (rdy[k] !== 1'b0 || r1[k] !== 32'h0 || r2[k] !== 32'h0) begin
                fails++;
                $display("[TB] FAIL async_reset inst%0d: ready=%b rs1=%h rs2=%h, required 0 0 0", k, rdy[k], r1[k], r2[k]);
            end
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            tick();
            tests++;
            if (rdy[0] !== expReady(0) || rdy[2] !== expReady(2)) begin
                fails++;
                $display("[TB] FAIL resweep edge%0d: readyA=%b readyC=%b, required %b %b", e, rdy[0], rdy[2], expReady(0), expReady(2));
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (r1[k] !== 32'h0) begin
                fails++;
                $display("[TB] FAIL post_reset_x3 inst%0d: rs1=%h, required 0", k, r1[k]);
            end
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++)
            for (int j = 0; j < 32; j++) mem[m][j] = 32'h0;
        test_reset();
        test_write();
        test_bypass();
        test_out_of_range();
        test_random();
        test_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
